// File: rtl/multiplier_unsigned_pkg.sv
// Shared widths and the per-stage pipeline record for the unsigned multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multiplier_unsigned_pkg;

  localparam int MUL_PIPELINE = 16;
  localparam int MUL_DATA_W   = 32;
  localparam int MUL_PROD_W   = 64;
  localparam int MUL_TAG_W    = 4;

  // One pipeline stage: partial product so far, multiplicand already shifted
  // into place for this stage, and the multiplier bits not yet consumed.
  typedef struct packed {
    logic                  valid;
    logic [MUL_TAG_W-1:0]  tag;
    logic [MUL_PROD_W-1:0] acc;
    logic [MUL_PROD_W-1:0] mcand;
    logic [MUL_DATA_W-1:0] mplr;
  } mul_stage_t;

endpackage

// File: rtl/multiplier_stage.sv
// One radix-4 step of the shift-add multiplier: folds two multiplier bits into acc.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module multiplier_stage
  import multiplier_unsigned_pkg::*;
(
  input  logic [MUL_PROD_W-1:0] acc,
  input  logic [MUL_PROD_W-1:0] mcand,
  input  logic [MUL_DATA_W-1:0] mplr,
  output logic [MUL_PROD_W-1:0] acc_next,
  output logic [MUL_PROD_W-1:0] mcand_next,
  output logic [MUL_DATA_W-1:0] mplr_next
);

  logic [MUL_PROD_W-1:0] pp0;
  logic [MUL_PROD_W-1:0] pp1;

  // Select the two partial products for the low multiplier bits and add them in.
  always_comb begin
    pp0        = mplr[0] ? mcand : '0;
    pp1        = mplr[1] ? {mcand[MUL_PROD_W-2:0], 1'b0} : '0;
    acc_next   = acc + pp0 + pp1;
    mcand_next = {mcand[MUL_PROD_W-3:0], 2'b00};
    mplr_next  = {2'b00, mplr[MUL_DATA_W-1:2]};
  end

endmodule

// File: rtl/multiplier_unsigned.sv
// Fully pipelined 32x32->64 unsigned multiplier, two multiplier bits per stage.
// Latency: 16 cycles, one operation accepted per cycle.
// Backpressure: none; results must be taken the cycle out_valid is high.
module multiplier_unsigned
  import multiplier_unsigned_pkg::*;
#(
  // Stage count is fixed by 32 bits / 2 bits per stage.
  parameter int PIPELINE = MUL_PIPELINE,
  // Must match MUL_TAG_W, which sizes the tag field in the stage record.
  parameter int TAG_W    = MUL_TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [MUL_DATA_W-1:0] multiplicand,
  input  logic [MUL_DATA_W-1:0] multiplier,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  output logic [MUL_DATA_W-1:0] product_hi,
  output logic [MUL_DATA_W-1:0] product_lo,
  output logic [TAG_W-1:0]      out_tag
);

  mul_stage_t stage_in  [PIPELINE];
  mul_stage_t stage_nxt [PIPELINE];
  mul_stage_t stage_q   [PIPELINE];

  for (genvar g = 0; g < PIPELINE; g++) begin : g_stage
    logic [MUL_PROD_W-1:0] acc_nxt;
    logic [MUL_PROD_W-1:0] mcand_nxt;
    logic [MUL_DATA_W-1:0] mplr_nxt;

    // Stage 0 starts a fresh product from the ports; later stages chain registers.
    if (g == 0) begin : g_head
      assign stage_in[g] = '{valid: in_valid,
                             tag:   in_tag,
                             acc:   '0,
                             mcand: {{(MUL_PROD_W-MUL_DATA_W){1'b0}}, multiplicand},
                             mplr:  multiplier};
    end else begin : g_body
      assign stage_in[g] = stage_q[g-1];
    end

    multiplier_stage u_stage (
      .acc        (stage_in[g].acc),
      .mcand      (stage_in[g].mcand),
      .mplr       (stage_in[g].mplr),
      .acc_next   (acc_nxt),
      .mcand_next (mcand_nxt),
      .mplr_next  (mplr_nxt)
    );

    assign stage_nxt[g] = '{valid: stage_in[g].valid,
                            tag:   stage_in[g].tag,
                            acc:   acc_nxt,
                            mcand: mcand_nxt,
                            mplr:  mplr_nxt};
  end

  // Advance every stage each cycle; flush squashes valid/tag/acc, reset clears all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PIPELINE; k++) begin
        stage_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < PIPELINE; k++) begin
        stage_q[k].valid <= 1'b0;
        stage_q[k].tag   <= '0;
        stage_q[k].acc   <= '0;
        stage_q[k].mcand <= stage_nxt[k].mcand;
        stage_q[k].mplr  <= stage_nxt[k].mplr;
      end
    end else begin
      for (int k = 0; k < PIPELINE; k++) begin
        stage_q[k] <= stage_nxt[k];
      end
    end
  end

  // A flush in the current cycle also hides the result already sitting in the last stage.
  assign out_valid  = stage_q[PIPELINE-1].valid & ~flush;
  assign product_hi = stage_q[PIPELINE-1].acc[MUL_PROD_W-1:MUL_DATA_W];
  assign product_lo = stage_q[PIPELINE-1].acc[MUL_DATA_W-1:0];
  assign out_tag    = stage_q[PIPELINE-1].tag;

endmodule
